// File: rtl/conv_window_sequencer_if.sv
// conv_window_sequencer_if: address-beat stream from the window sequencer to its memory consumer.
interface conv_window_sequencer_if #(
   parameter int ADDR_W = 16,
   parameter int DIM_W  = 8
);
   logic              addr_valid;
   logic              addr_ready;
   logic [ADDR_W-1:0] image_addr;
   logic [ADDR_W-1:0] filter_addr;
   logic              pad;
   logic              last_tap;
   logic [DIM_W-1:0]  out_x;
   logic [DIM_W-1:0]  out_y;
   modport master (
      output addr_valid, image_addr, filter_addr, pad, last_tap, out_x, out_y,
      input  addr_ready
   );
   modport slave (
      input  addr_valid, image_addr, filter_addr, pad, last_tap, out_x, out_y,
      output addr_ready
   );
endinterface

// File: rtl/conv_window_sequencer.sv
// conv_window_sequencer: walks output centres and filter taps, emitting image/filter
// address pairs with zero-pad and last-tap flags over a valid/ready stream.
module conv_window_sequencer #(
   parameter int ADDR_W   = 16,
   parameter int DIM_W    = 8,
   parameter int DEPTH_W  = 9,
   parameter int HALF_W   = 2,
   parameter int STRIDE_W = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DIM_W-1:0]        image_dim,
   input  logic [DEPTH_W-1:0]      image_depth,
   input  logic [ADDR_W-1:0]       image_memory_offset,
   input  logic [ADDR_W-1:0]       filter_memory_offset,
   input  logic [HALF_W-1:0]       filter_halfsize,
   input  logic [STRIDE_W-1:0]     filter_stride,
   conv_window_sequencer_if.master addr_if,
   output logic                    busy,
   output logic                    done
);
   localparam int KW = HALF_W + 1;
   localparam int CW = DIM_W + 2;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t state_q, state_d;
   logic [DIM_W-1:0]    dim_q, dim_d, cx_q, cx_d, cy_q, cy_d;
   logic [DEPTH_W-1:0]  depth_q, depth_d, z_q, z_d;
   logic [HALF_W-1:0]   half_q, half_d;
   logic [STRIDE_W-1:0] stride_q, stride_d, s_eff;
   logic [KW-1:0]       kx_q, kx_d, ky_q, ky_d, k2;
   logic [ADDR_W-1:0]   ioff_q, ioff_d, foff_q, foff_d, t_q, t_d;
   logic [ADDR_W-1:0]   sd_q, sd_d, hdh_q, hdh_d, kstep_q, kstep_d, zstep_q, zstep_d;
   logic [ADDR_W-1:0]   rowc_q, rowc_d, ptr_q, ptr_d;
   logic [ADDR_W-1:0]   d_a, h_a, dd_in, hd_in, sd_in;
   logic [DIM_W:0]      cx_nx, cy_nx;
   logic [CW-1:0]       ix, iy;
   logic                kx_end, ky_end, z_end, cx_end, cy_end, tap_end, run, fire, pad_w;

   function automatic logic [ADDR_W-1:0] mul_sa(input logic [ADDR_W-1:0] a, input logic [DIM_W-1:0] b);
      logic [ADDR_W-1:0] p;
      p = '0;
      for (int i = 0; i < DIM_W; i++) p = b[i] ? p + (a << i) : p;
      return p;
   endfunction

   // Products are formed once at start by shift-add; the walk itself only adds.
   assign s_eff = (filter_stride == '0) ? STRIDE_W'(1) : filter_stride;
   assign d_a   = ADDR_W'(image_dim);
   assign h_a   = ADDR_W'(filter_halfsize);
   assign dd_in = mul_sa(d_a, image_dim);
   assign hd_in = mul_sa(d_a, DIM_W'(filter_halfsize));
   assign sd_in = mul_sa(d_a, DIM_W'(s_eff));

   assign run     = state_q == RUN;
   assign fire    = run & addr_if.addr_ready;
   assign k2      = {half_q, 1'b0};
   assign kx_end  = kx_q == k2;
   assign ky_end  = ky_q == k2;
   assign z_end   = z_q == depth_q - DEPTH_W'(1);
   assign tap_end = kx_end & ky_end & z_end;
   assign cx_nx   = {1'b0, cx_q} + (DIM_W + 1)'(stride_q);
   assign cy_nx   = {1'b0, cy_q} + (DIM_W + 1)'(stride_q);
   assign cx_end  = cx_nx >= {1'b0, dim_q};
   assign cy_end  = cy_nx >= {1'b0, dim_q};
   assign ix      = {2'b00, cx_q} + CW'(kx_q) - CW'(half_q);
   assign iy      = {2'b00, cy_q} + CW'(ky_q) - CW'(half_q);
   assign pad_w   = ix[CW-1] | (ix[CW-2:0] >= {1'b0, dim_q}) | iy[CW-1] | (iy[CW-2:0] >= {1'b0, dim_q});

   always_comb begin
      state_d  = state_q;
      dim_d    = dim_q;
      depth_d  = depth_q;
      half_d   = half_q;
      stride_d = stride_q;
      ioff_d   = ioff_q;
      foff_d   = foff_q;
      sd_d     = sd_q;
      hdh_d    = hdh_q;
      kstep_d  = kstep_q;
      zstep_d  = zstep_q;
      cx_d     = cx_q;
      cy_d     = cy_q;
      z_d      = z_q;
      kx_d     = kx_q;
      ky_d     = ky_q;
      t_d      = t_q;
      rowc_d   = rowc_q;
      ptr_d    = ptr_q;
      if (state_q == IDLE && start) begin
         state_d  = (image_dim == '0 || image_depth == '0) ? DONE : RUN;
         dim_d    = image_dim;
         depth_d  = image_depth;
         half_d   = filter_halfsize;
         stride_d = s_eff;
         ioff_d   = image_memory_offset;
         foff_d   = filter_memory_offset;
         sd_d     = sd_in;
         hdh_d    = hd_in + h_a;
         kstep_d  = d_a - (h_a << 1);
         zstep_d  = dd_in - (hd_in << 1) - (h_a << 1);
         cx_d     = '0;
         cy_d     = '0;
         z_d      = '0;
         kx_d     = '0;
         ky_d     = '0;
         t_d      = '0;
         rowc_d   = '0;
         ptr_d    = '0 - (hd_in + h_a);
      end else if (fire) begin
         // ptr tracks z*D*D + iy*D + ix; each loop wrap adds the matching precomputed step.
         t_d    = tap_end ? '0 : t_q + ADDR_W'(1);
         kx_d   = kx_end ? '0 : kx_q + KW'(1);
         ky_d   = kx_end ? (ky_end ? '0 : ky_q + KW'(1)) : ky_q;
         z_d    = (kx_end & ky_end) ? (z_end ? '0 : z_q + DEPTH_W'(1)) : z_q;
         ptr_d  = !kx_end ? ptr_q + ADDR_W'(1) :
                  !ky_end ? ptr_q + kstep_q :
                  !z_end  ? ptr_q + zstep_q :
                  !cx_end ? rowc_q + ADDR_W'(cx_nx) - hdh_q :
                            rowc_q + sd_q - hdh_q;
         cx_d   = tap_end ? (cx_end ? '0 : cx_nx[DIM_W-1:0]) : cx_q;
         cy_d   = (tap_end & cx_end) ? cy_nx[DIM_W-1:0] : cy_q;
         rowc_d = (tap_end & cx_end) ? rowc_q + sd_q : rowc_q;
         state_d = (tap_end & cx_end & cy_end) ? DONE : state_q;
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dim_q    <= '0;
         depth_q  <= '0;
         half_q   <= '0;
         stride_q <= '0;
         ioff_q   <= '0;
         foff_q   <= '0;
         sd_q     <= '0;
         hdh_q    <= '0;
         kstep_q  <= '0;
         zstep_q  <= '0;
         cx_q     <= '0;
         cy_q     <= '0;
         z_q      <= '0;
         kx_q     <= '0;
         ky_q     <= '0;
         t_q      <= '0;
         rowc_q   <= '0;
         ptr_q    <= '0;
      end else begin
         dim_q    <= dim_d;
         depth_q  <= depth_d;
         half_q   <= half_d;
         stride_q <= stride_d;
         ioff_q   <= ioff_d;
         foff_q   <= foff_d;
         sd_q     <= sd_d;
         hdh_q    <= hdh_d;
         kstep_q  <= kstep_d;
         zstep_q  <= zstep_d;
         cx_q     <= cx_d;
         cy_q     <= cy_d;
         z_q      <= z_d;
         kx_q     <= kx_d;
         ky_q     <= ky_d;
         t_q      <= t_d;
         rowc_q   <= rowc_d;
         ptr_q    <= ptr_d;
      end
   end

   assign addr_if.addr_valid  = run;
   assign addr_if.pad         = run & pad_w;
   assign addr_if.last_tap    = run & tap_end;
   assign addr_if.image_addr  = pad_w ? ioff_q : ioff_q + ptr_q;
   assign addr_if.filter_addr = foff_q + t_q;
   assign addr_if.out_x       = cx_q;
   assign addr_if.out_y       = cy_q;
   assign busy                = run;
   assign done                = state_q == DONE;
endmodule

// File: doc/conv_window_sequencer.md
Name: conv_window_sequencer

Overview:
Parametrised address sequencer for the next-generation convolution accelerator. Given the same CPU-supplied configuration as Accel (image dim/depth, memory offsets, filter halfsize/stride), it walks every output position and every filter tap. It emits one image/filter address pair per beat over a valid/ready handshake, flagging zero-padding taps and the last tap of each output. Unlike Accel it supports generic widths, zero-padded "same" borders, backpressure, and a correctly timed done pulse.

Parameters:
ADDR_W, 16, memory address width
DIM_W, 8, image x/y dimension width
DEPTH_W, 9, image depth (z) width
HALF_W, 2, filter halfsize width; filter side = 2h+1
STRIDE_W, 3, filter stride width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low
start  in  1  begin a run; sampled only in IDLE
image_dim  in  DIM_W  square image side D
image_depth  in  DEPTH_W  channel count Z
image_memory_offset  in  ADDR_W  image base address
filter_memory_offset  in  ADDR_W  filter base address
filter_halfsize  in  HALF_W  h
filter_stride  in  STRIDE_W  S; 0 is treated as 1
addr_valid  out  1  beat available
addr_ready  in  1  consumer accepts beat
image_addr  out  ADDR_W  image word address
filter_addr  out  ADDR_W  filter word address
pad  out  1  tap lies outside the image; consumer uses 0
last_tap  out  1  final tap of current output pixel
out_x  out  DIM_W  current output centre x
out_y  out  DIM_W  current output centre y
busy  out  1  run in progress
done  out  1  one-cycle pulse, run complete

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs 0: addr_valid, busy, done, pad, last_tap, image_addr, filter_addr, out_x, out_y.
- States: IDLE -> RUN on start. RUN -> DONE on acceptance of the final beat. DONE -> IDLE unconditionally after 1 cycle. done=1 only in DONE. busy=1 in RUN.
- Configuration inputs are latched on the start cycle. Later input changes have no effect until the next start. start in RUN/DONE is ignored.
- If D==0 or Z==0 on start: go IDLE->DONE directly. No beats are emitted and done is pulsed.
- The first addr_valid rises the cycle after start is sampled.
- Loop order, outermost first: cy = 0,S,2S,.. while cy<D; cx likewise; z = 0..Z-1; ky = -h..h; kx = -h..h.
- Per-output beat count is Z*(2h+1)^2.
- filter_addr = filter_memory_offset + t, where t is the tap index 0..Z*(2h+1)^2-1 within the output. t restarts at 0 for each output.
- iy=cy+ky and ix=cx+kx are signed.
- If 0<=ix<D and 0<=iy<D: pad=0 and image_addr = image_memory_offset + z*D*D + iy*D + ix.
- Otherwise pad=1 and image_addr = image_memory_offset.
- All address arithmetic is modulo 2^ADDR_W. Addresses are computed incrementally (adders/accumulators only; no multiplier instances).
- last_tap=1 on the beat with z=Z-1, ky=kx=h.
- out_x/out_y equal cx/cy of the current beat.
- Handshake: a beat transfers when addr_valid && addr_ready. While addr_valid=1 and addr_ready=0, all beat outputs must hold stable.
- After a transfer, the next beat is presented the following cycle, with addr_valid remaining 1. Sustained throughput is 1 beat/cycle when addr_ready is tied high.
- addr_valid drops to 0 the cycle after the final transfer, which is the cycle done=1.
- Reset mid-run aborts immediately to IDLE with reset values. There is no done pulse.

Test Plan:
- D=5, Z=3, h=1, S=1, image off 0, filter off 1000, ready=1 -> exactly 675 beats. Beat 0: out(0,0), pad=1, filter_addr=1000. Beat 4: image_addr=0, pad=0, filter_addr=1004. Beat 26: last_tap=1, filter_addr=1026. done is 1 cycle wide, 1 cycle after the last transfer.
- Same config, output (1,1) centre tap (z=0, ky=kx=0) -> image_addr=6, filter_addr=1004, pad=0. For z=2: image_addr=56, filter_addr=1022.
- Same config with S=2 -> 243 beats. out_x/out_y visit only 0,2,4. S=0 behaves identically to S=1 (675 beats).
- Backpressure: drop addr_ready for 3 cycles at beat 10 -> outputs are bit-identical across the stall, no beat is lost or duplicated, and the total is still 675.
- Z=0 with start -> no addr_valid; done pulses 1 cycle after start. Start asserted during RUN -> ignored, beat count unchanged.
- Assert rst low at beat 100 -> asynchronous clear of all outputs and no done. A fresh start then produces a complete 675-beat run from beat 0.
